servo_angle_stepper: RTL

- Converts synchronized increment/decrement button levels and a 2-bit speed select into a saturating servo angle in degrees.
- Sits directly upstream of the servo PWM stage. Its deg output feeds the degree-to-duty conversion (duty = ONE_DEG_NUM*deg + MIN_NUM).
- Press behaviour: one immediate step on press, then auto-repeat after a hold delay.

---
 rtl/servo_pkg.sv | 33 +++
 rtl/servo_step_sat.sv | 40 ++++
 rtl/servo_angle_stepper.sv | 118 +++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types and constants for the servo angle path
// Purpose : FSM state type, speed-to-step lookup and the system clock rate
//           shared with the downstream PWM stage.
// Contents: CLK_HZ, state_t, STEP_SPD0..3, speed_to_step()
package servo_pkg;

  localparam int unsigned CLK_HZ = 50000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  // Step size in degrees for each speed select code.
  localparam logic [3:0] STEP_SPD0 = 4'd1;
  localparam logic [3:0] STEP_SPD1 = 4'd2;
  localparam logic [3:0] STEP_SPD2 = 4'd5;
  localparam logic [3:0] STEP_SPD3 = 4'd10;

  function automatic logic [3:0] speed_to_step(input logic [1:0] speed);
    logic [3:0] step;
    case (speed)
      2'b00:   step = STEP_SPD0;
      2'b01:   step = STEP_SPD1;
      2'b10:   step = STEP_SPD2;
      default: step = STEP_SPD3;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/servo_step_sat.sv
// rtl/servo_step_sat.sv - saturating add/sub of the angle by one step
// Purpose : next = up ? min(deg+step, MAX_DEG) : max(deg-step, 0), computed
//           in 9 bits so nothing wraps.
// Ports   : i_deg      current angle
//           i_step     step size in degrees
//           i_up       1 = add, 0 = subtract
//           o_next_deg saturated result
//           o_changed  result differs from i_deg
module servo_step_sat
  import servo_pkg::*;
#(
  parameter int unsigned MAX_DEG = 180
) (
  input  logic [7:0] i_deg,
  input  logic [3:0] i_step,
  input  logic       i_up,
  output logic [7:0] o_next_deg,
  output logic       o_changed
);

  localparam logic [8:0] MAX9 = 9'(MAX_DEG);
  localparam logic [7:0] MAX8 = 8'(MAX_DEG);

  logic [8:0] w_sum;
  logic [8:0] w_deg9;
  logic [8:0] w_step9;

  always_comb begin
    w_deg9  = {1'b0, i_deg};
    w_step9 = {5'b0, i_step};
    w_sum   = w_deg9 + w_step9;
    if (i_up) begin
      o_next_deg = (w_sum > MAX9) ? MAX8 : w_sum[7:0];
    end else begin
      o_next_deg = (w_deg9 < w_step9) ? 8'd0 : (i_deg - {4'b0, i_step});
    end
    o_changed = (o_next_deg != i_deg);
  end

endmodule

// File: rtl/servo_angle_stepper.sv
// rtl/servo_angle_stepper.sv - button-driven saturating servo angle with auto-repeat
// Purpose : One step on press, first auto-repeat HOLD_CYC clocks later, then
//           every REPEAT_CYC clocks while the button stays held.
// Ports   : i_clk, i_rst_n (async active-low)
//           i_inc, i_dec   debounced/synchronized button levels
//           i_speed        step select 00=1,01=2,10=5,11=10 degrees
//           o_deg          current angle 0..MAX_DEG
//           o_at_min/o_at_max  combinational limit flags
//           o_step_pulse   one cycle, coincident with a new o_deg value
module servo_angle_stepper
  import servo_pkg::*;
#(
  parameter int unsigned MAX_DEG    = 180,
  parameter int unsigned INIT_DEG   = 90,
  parameter int unsigned HOLD_CYC   = 25000000,
  parameter int unsigned REPEAT_CYC = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic [1:0] i_speed,
  output logic [7:0] o_deg,
  output logic       o_at_min,
  output logic       o_at_max,
  output logic       o_step_pulse
);

  localparam logic [31:0] HOLD_LIM   = 32'(HOLD_CYC - 1);
  localparam logic [31:0] REPEAT_LIM = 32'(REPEAT_CYC - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_dir_up;
  logic [7:0]  r_deg;
  logic        r_step_pulse;

  logic [3:0]  w_step;
  logic        w_up;
  logic [7:0]  w_next_deg;
  logic        w_changed;
  logic        w_active;
  logic        w_other;
  logic [31:0] w_limit;

  // In IDLE the direction comes straight from the button; afterwards from r_dir_up.
  assign w_step   = speed_to_step(i_speed);
  assign w_up     = (r_state == IDLE) ? i_inc : r_dir_up;
  assign w_active = r_dir_up ? i_inc : i_dec;
  assign w_other  = r_dir_up ? i_dec : i_inc;
  assign w_limit  = (r_state == HOLD) ? HOLD_LIM : REPEAT_LIM;

  servo_step_sat #(
    .MAX_DEG (MAX_DEG)
  ) u_step_sat (
    .i_deg      (r_deg),
    .i_step     (w_step),
    .i_up       (w_up),
    .o_next_deg (w_next_deg),
    .o_changed  (w_changed)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_dir_up     <= 1'b0;
      r_deg        <= 8'(INIT_DEG);
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_inc ^ i_dec) begin
            r_deg        <= w_next_deg;
            r_step_pulse <= w_changed;
            r_dir_up     <= i_inc;
            r_cnt        <= '0;
            r_state      <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          // Second button wins over everything: lock out until both released.
          if (w_other) begin
            r_cnt   <= '0;
            r_state <= WAIT_REL;
          end else if (!w_active) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (r_cnt == w_limit) begin
            r_deg        <= w_next_deg;
            r_step_pulse <= w_changed;
            r_cnt        <= '0;
            r_state      <= REPEAT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        WAIT_REL: begin
          if (!i_inc && !i_dec) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_deg        = r_deg;
  assign o_step_pulse = r_step_pulse;
  assign o_at_min     = (r_deg == 8'd0);
  assign o_at_max     = (r_deg == 8'(MAX_DEG));

endmodule
